// File: rtl/ooo_pkg.sv
// ---------------------------------------------------------------------------
// ooo_pkg
// Shared widths, CDB broadcast type and reservation-station entry type.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ooo_pkg;

  localparam int DATA_W    = 16;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int OP_W      = 4;
  localparam int CDB_PORTS = 4;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  index;
    logic [DATA_W-1:0] value;
  } cdb_bcast_t;

  typedef cdb_bcast_t [CDB_PORTS-1:0] cdb_bus_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic              a_rdy;
    logic [DATA_W-1:0] a_val;
    logic [TAG_W-1:0]  a_owner;
    logic              b_rdy;
    logic [DATA_W-1:0] b_val;
    logic [TAG_W-1:0]  b_owner;
    logic [TAG_W-1:0]  rob_tag;
  } rs_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] value;
  } cdb_hit_t;

  // Searches from the highest port down so the lowest matching port wins.
  function automatic cdb_hit_t cdb_lookup(input cdb_bus_t bus, input logic [TAG_W-1:0] owner);
    cdb_hit_t res;
    res = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (bus[p].valid && (bus[p].index == owner)) begin
        res.hit   = 1'b1;
        res.value = bus[p].value;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_age_select.sv
// ---------------------------------------------------------------------------
// rs_age_select
// Grants the ready entry with the smallest age rank (one-hot) plus found flag.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rs_age_select #(
  parameter int DEPTH = 4,
  parameter int AGE_W = 2
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] ready,
  input  logic [AGE_W-1:0] age [DEPTH],
  output logic [DEPTH-1:0] grant,
  output logic             found
);

  logic [DEPTH-1:0] w_cand;

  assign w_cand = valid & ready;
  assign found  = |w_cand;

  // Ranks of valid entries are unique, so at most one candidate survives.
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = w_cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && w_cand[j] && (age[j] < age[i])) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
// Operand-wait buffer: captures CDB results, issues the oldest ready op.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reservation_station #(
  parameter int DEPTH     = 4,
  parameter int CDB_PORTS = ooo_pkg::CDB_PORTS,
  parameter int DATA_W    = ooo_pkg::DATA_W,
  parameter int TAG_W     = ooo_pkg::TAG_W,
  parameter int OP_W      = ooo_pkg::OP_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        disp_valid,
  input  logic [OP_W-1:0]             disp_opcode,
  input  logic                        disp_a_valid,
  input  logic [DATA_W-1:0]           disp_a_value,
  input  logic [TAG_W-1:0]            disp_a_owner,
  input  logic                        disp_b_valid,
  input  logic [DATA_W-1:0]           disp_b_value,
  input  logic [TAG_W-1:0]            disp_b_owner,
  input  logic [TAG_W-1:0]            disp_rob_tag,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_index,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_value,
  input  logic                        flush,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OP_W-1:0]             issue_opcode,
  output logic [DATA_W-1:0]           issue_a,
  output logic [DATA_W-1:0]           issue_b,
  output logic [TAG_W-1:0]            issue_rob_tag
);

  import ooo_pkg::rs_entry_t;
  import ooo_pkg::cdb_bus_t;
  import ooo_pkg::cdb_hit_t;
  import ooo_pkg::cdb_lookup;

  localparam int AGE_W = $clog2(DEPTH);
  localparam int CNT_W = AGE_W + 1;

  rs_entry_t         r_entry     [DEPTH];
  rs_entry_t         w_entry_nxt [DEPTH];
  logic [AGE_W-1:0]  r_age       [DEPTH];
  logic [AGE_W-1:0]  w_age_nxt   [DEPTH];

  logic              r_issue_valid;
  logic [OP_W-1:0]   r_issue_opcode;
  logic [DATA_W-1:0] r_issue_a;
  logic [DATA_W-1:0] r_issue_b;
  logic [TAG_W-1:0]  r_issue_tag;

  cdb_bus_t          w_cdb;
  cdb_hit_t          w_a_hit [DEPTH];
  cdb_hit_t          w_b_hit [DEPTH];
  cdb_hit_t          w_disp_a_hit;
  cdb_hit_t          w_disp_b_hit;

  logic [CNT_W-1:0]  w_count;
  logic [DEPTH-1:0]  w_valid_vec;
  logic [DEPTH-1:0]  w_ready_vec;
  logic [DEPTH-1:0]  w_grant;
  logic              w_found;
  logic              w_load;
  logic              w_disp;
  logic [AGE_W-1:0]  w_free_idx;
  logic [AGE_W-1:0]  w_disp_age;
  rs_entry_t         w_disp_entry;

  logic [OP_W-1:0]   w_sel_opcode;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [AGE_W-1:0]  w_sel_age;

  generate
    for (genvar p = 0; p < CDB_PORTS; p++) begin : g_cdb
      assign w_cdb[p].valid = cdb_valid[p];
      assign w_cdb[p].index = cdb_index[p*TAG_W +: TAG_W];
      assign w_cdb[p].value = cdb_value[p*DATA_W +: DATA_W];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_status
      assign w_valid_vec[i] = r_entry[i].valid;
      assign w_ready_vec[i] = r_entry[i].a_rdy & r_entry[i].b_rdy;
      assign w_a_hit[i]     = cdb_lookup(w_cdb, r_entry[i].a_owner);
      assign w_b_hit[i]     = cdb_lookup(w_cdb, r_entry[i].b_owner);
    end
  endgenerate

  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CNT_W'(r_entry[i].valid);
    end
  end

  assign count = w_count;
  assign full  = (w_count == CNT_W'(DEPTH));

  rs_age_select #(
    .DEPTH (DEPTH),
    .AGE_W (AGE_W)
  ) u_age_select (
    .valid (w_valid_vec),
    .ready (w_ready_vec),
    .age   (r_age),
    .grant (w_grant),
    .found (w_found)
  );

  assign w_load = w_found & (~r_issue_valid | issue_ready);
  assign w_disp = disp_valid & ~full & ~flush;

  always_comb begin
    w_sel_opcode = '0;
    w_sel_a      = '0;
    w_sel_b      = '0;
    w_sel_tag    = '0;
    w_sel_age    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        w_sel_opcode = r_entry[i].opcode;
        w_sel_a      = r_entry[i].a_val;
        w_sel_b      = r_entry[i].b_val;
        w_sel_tag    = r_entry[i].rob_tag;
        w_sel_age    = r_age[i];
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_entry[i].valid) begin
        w_free_idx = AGE_W'(i);
      end
    end
  end

  // New op takes rank = count, already compacted if an issue frees a slot this edge.
  assign w_disp_age   = AGE_W'(w_count - CNT_W'(w_load));
  assign w_disp_a_hit = cdb_lookup(w_cdb, disp_a_owner);
  assign w_disp_b_hit = cdb_lookup(w_cdb, disp_b_owner);

  always_comb begin
    w_disp_entry         = '0;
    w_disp_entry.valid   = 1'b1;
    w_disp_entry.opcode  = disp_opcode;
    w_disp_entry.a_owner = disp_a_owner;
    w_disp_entry.b_owner = disp_b_owner;
    w_disp_entry.rob_tag = disp_rob_tag;
    w_disp_entry.a_rdy   = disp_a_valid | w_disp_a_hit.hit;
    w_disp_entry.a_val   = disp_a_valid ? disp_a_value : w_disp_a_hit.value;
    w_disp_entry.b_rdy   = disp_b_valid | w_disp_b_hit.hit;
    w_disp_entry.b_val   = disp_b_valid ? disp_b_value : w_disp_b_hit.value;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_nxt[i] = r_entry[i];
      w_age_nxt[i]   = r_age[i];
      if (r_entry[i].valid) begin
        if (!r_entry[i].a_rdy && w_a_hit[i].hit) begin
          w_entry_nxt[i].a_rdy = 1'b1;
          w_entry_nxt[i].a_val = w_a_hit[i].value;
        end
        if (!r_entry[i].b_rdy && w_b_hit[i].hit) begin
          w_entry_nxt[i].b_rdy = 1'b1;
          w_entry_nxt[i].b_val = w_b_hit[i].value;
        end
        if (w_load && (r_age[i] > w_sel_age)) begin
          w_age_nxt[i] = r_age[i] - AGE_W'(1);
        end
        if (w_load && w_grant[i]) begin
          w_entry_nxt[i].valid = 1'b0;
        end
      end
      if (w_disp && (w_free_idx == AGE_W'(i))) begin
        w_entry_nxt[i] = w_disp_entry;
        w_age_nxt[i]   = w_disp_age;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
        r_age[i]   <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
        r_age[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= w_entry_nxt[i];
        r_age[i]   <= w_age_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_valid  <= 1'b0;
      r_issue_opcode <= '0;
      r_issue_a      <= '0;
      r_issue_b      <= '0;
      r_issue_tag    <= '0;
    end else if (flush) begin
      r_issue_valid  <= 1'b0;
      r_issue_opcode <= '0;
      r_issue_a      <= '0;
      r_issue_b      <= '0;
      r_issue_tag    <= '0;
    end else if (w_load) begin
      r_issue_valid  <= 1'b1;
      r_issue_opcode <= w_sel_opcode;
      r_issue_a      <= w_sel_a;
      r_issue_b      <= w_sel_b;
      r_issue_tag    <= w_sel_tag;
    end else if (issue_ready) begin
      r_issue_valid  <= 1'b0;
    end
  end

  assign issue_valid   = r_issue_valid;
  assign issue_opcode  = r_issue_opcode;
  assign issue_a       = r_issue_a;
  assign issue_b       = r_issue_b;
  assign issue_rob_tag = r_issue_tag;

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
// Directed scenarios plus random traffic against an in-order queue model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reservation_station;

  localparam int DEPTH = 4;
  localparam int CDB   = 4;
  localparam int DW    = 16;
  localparam int TW    = 4;
  localparam int OW    = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               disp_valid = 1'b0;
  logic [OW-1:0]      disp_opcode = '0;
  logic               disp_a_valid = 1'b0;
  logic [DW-1:0]      disp_a_value = '0;
  logic [TW-1:0]      disp_a_owner = '0;
  logic               disp_b_valid = 1'b0;
  logic [DW-1:0]      disp_b_value = '0;
  logic [TW-1:0]      disp_b_owner = '0;
  logic [TW-1:0]      disp_rob_tag = '0;
  logic               full;
  logic [$clog2(DEPTH):0] count;
  logic [CDB-1:0]     cdb_valid = '0;
  logic [CDB*TW-1:0]  cdb_index = '0;
  logic [CDB*DW-1:0]  cdb_value = '0;
  logic               flush = 1'b0;
  logic               issue_valid;
  logic               issue_ready = 1'b0;
  logic [OW-1:0]      issue_opcode;
  logic [DW-1:0]      issue_a;
  logic [DW-1:0]      issue_b;
  logic [TW-1:0]      issue_rob_tag;

  reservation_station #(
    .DEPTH(DEPTH), .CDB_PORTS(CDB), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode),
    .disp_a_valid(disp_a_valid), .disp_a_value(disp_a_value), .disp_a_owner(disp_a_owner),
    .disp_b_valid(disp_b_valid), .disp_b_value(disp_b_value), .disp_b_owner(disp_b_owner),
    .disp_rob_tag(disp_rob_tag), .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_value(cdb_value),
    .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_a(issue_a), .issue_b(issue_b),
    .issue_rob_tag(issue_rob_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] op;
    logic          a_rdy;
    logic [DW-1:0] a_val;
    logic [TW-1:0] a_own;
    logic          b_rdy;
    logic [DW-1:0] b_val;
    logic [TW-1:0] b_own;
    logic [TW-1:0] tag;
  } m_op_t;

  // Queue kept oldest-first; issue register modelled separately.
  m_op_t m_q[$];
  logic  m_iv = 1'b0;
  m_op_t m_iss;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [TW-1:0] own, output logic hit, output logic [DW-1:0] val);
    hit = 1'b0;
    val = '0;
    for (int p = 0; p < CDB; p++) begin
      if (!hit && cdb_valid[p] && (cdb_index[p*TW +: TW] == own)) begin
        hit = 1'b1;
        val = cdb_value[p*DW +: DW];
      end
    end
  endtask

  task automatic model_step();
    int    pre_size;
    int    ci;
    logic  hit;
    logic [DW-1:0] val;
    m_op_t e;
    if (!rst_n || flush) begin
      m_q.delete();
      m_iv = 1'b0;
      return;
    end
    pre_size = m_q.size();
    ci = -1;
    for (int i = 0; i < m_q.size(); i++) begin
      if (m_q[i].a_rdy && m_q[i].b_rdy) begin
        ci = i;
        break;
      end
    end
    if (ci >= 0 && (!m_iv || issue_ready)) begin
      m_iss = m_q[ci];
      m_iv  = 1'b1;
      m_q.delete(ci);
    end else if (issue_ready) begin
      m_iv = 1'b0;
    end
    for (int i = 0; i < m_q.size(); i++) begin
      if (!m_q[i].a_rdy) begin
        lookup(m_q[i].a_own, hit, val);
        if (hit) begin m_q[i].a_rdy = 1'b1; m_q[i].a_val = val; end
      end
      if (!m_q[i].b_rdy) begin
        lookup(m_q[i].b_own, hit, val);
        if (hit) begin m_q[i].b_rdy = 1'b1; m_q[i].b_val = val; end
      end
    end
    if (disp_valid && pre_size < DEPTH) begin
      e.op = disp_opcode; e.tag = disp_rob_tag;
      e.a_own = disp_a_owner; e.b_own = disp_b_owner;
      e.a_rdy = disp_a_valid; e.a_val = disp_a_value;
      e.b_rdy = disp_b_valid; e.b_val = disp_b_value;
      if (!e.a_rdy) begin
        lookup(e.a_own, hit, val);
        if (hit) begin e.a_rdy = 1'b1; e.a_val = val; end
      end
      if (!e.b_rdy) begin
        lookup(e.b_own, hit, val);
        if (hit) begin e.b_rdy = 1'b1; e.b_val = val; end
      end
      m_q.push_back(e);
    end
  endtask

  task automatic compare();
    check("issue_valid", {31'b0, issue_valid}, {31'b0, m_iv});
    check("count", {29'b0, count}, m_q.size());
    check("full", {31'b0, full}, {31'b0, (m_q.size() == DEPTH)});
    if (m_iv) begin
      check("issue_opcode", {28'b0, issue_opcode}, {28'b0, m_iss.op});
      check("issue_a", {16'b0, issue_a}, {16'b0, m_iss.a_val});
      check("issue_b", {16'b0, issue_b}, {16'b0, m_iss.b_val});
      check("issue_rob_tag", {28'b0, issue_rob_tag}, {28'b0, m_iss.tag});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = '0;
    flush      = 1'b0;
  endtask

  task automatic drive_disp(input logic [OW-1:0] op, input logic av, input logic [DW-1:0] aval,
                            input logic [TW-1:0] aown, input logic bv, input logic [DW-1:0] bval,
                            input logic [TW-1:0] bown, input logic [TW-1:0] tag);
    disp_valid = 1'b1; disp_opcode = op;
    disp_a_valid = av; disp_a_value = aval; disp_a_owner = aown;
    disp_b_valid = bv; disp_b_value = bval; disp_b_owner = bown;
    disp_rob_tag = tag;
  endtask

  task automatic drive_cdb(input int port, input logic [TW-1:0] idx, input logic [DW-1:0] val);
    cdb_valid[port] = 1'b1;
    cdb_index[port*TW +: TW] = idx;
    cdb_value[port*DW +: DW] = val;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_q.delete();
    m_iv = 1'b0;
    compare();
    check("reset_count", {29'b0, count}, 32'd0);

    // Ready op dispatched in cycle 0 presents in cycle 2.
    issue_ready = 1'b1;
    drive_disp(4'h1, 1'b1, 16'h0005, 4'h0, 1'b1, 16'h0003, 4'h0, 4'h2);
    cyc();
    idle();
    check("t2_not_yet", {31'b0, issue_valid}, 32'd0);
    cyc();
    check("t2_valid", {31'b0, issue_valid}, 32'd1);
    check("t2_a", {16'b0, issue_a}, 32'h0005);
    check("t2_b", {16'b0, issue_b}, 32'h0003);
    check("t2_tag", {28'b0, issue_rob_tag}, 32'h2);
    cyc(); cyc();

    // Wakeup through port 2.
    drive_disp(4'h2, 1'b0, 16'h0000, 4'h7, 1'b1, 16'h0001, 4'h0, 4'h5);
    cyc();
    idle();
    cyc(); cyc();
    drive_cdb(2, 4'h7, 16'hBEEF);
    cyc();
    idle();
    check("t3a_wait", {31'b0, issue_valid}, 32'd0);
    cyc();
    check("t3a_valid", {31'b0, issue_valid}, 32'd1);
    check("t3a_a", {16'b0, issue_a}, 32'hBEEF);
    cyc(); cyc();

    // Bypass at dispatch through port 0.
    drive_disp(4'h3, 1'b1, 16'h0011, 4'h0, 1'b0, 16'h0000, 4'h9, 4'h6);
    drive_cdb(0, 4'h9, 16'h0042);
    cyc();
    idle();
    cyc();
    check("t3b_valid", {31'b0, issue_valid}, 32'd1);
    check("t3b_b", {16'b0, issue_b}, 32'h0042);
    cyc(); cyc();

    // Backpressure and full.
    issue_ready = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      drive_disp(4'h4, 1'b1, 16'(t * 3), 4'h0, 1'b1, 16'(t), 4'h0, 4'(t));
      cyc();
    end
    idle();
    check("t4_hold_tag", {28'b0, issue_rob_tag}, 32'd1);
    check("t4_count", {29'b0, count}, 32'd4);
    check("t4_full", {31'b0, full}, 32'd1);
    issue_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check("t4_order", {28'b0, issue_rob_tag}, k);
      cyc();
    end
    check("t4_drained", {31'b0, issue_valid}, 32'd0);
    cyc();
    check("t4_no_tag6", {31'b0, issue_valid}, 32'd0);

    // Younger ready op overtakes older waiting op.
    drive_disp(4'h5, 1'b0, 16'h0000, 4'hA, 1'b1, 16'h0002, 4'h0, 4'h3);
    cyc();
    drive_disp(4'h6, 1'b1, 16'h0007, 4'h0, 1'b1, 16'h0008, 4'h0, 4'h4);
    cyc();
    idle();
    cyc();
    check("t5_first", {28'b0, issue_rob_tag}, 32'd4);
    drive_cdb(1, 4'hA, 16'h1234);
    cyc();
    idle();
    cyc();
    check("t5_second", {28'b0, issue_rob_tag}, 32'd3);
    check("t5_a", {16'b0, issue_a}, 32'h1234);
    cyc(); cyc();

    // Flush beats a simultaneous dispatch.
    issue_ready = 1'b0;
    for (int t = 9; t <= 12; t++) begin
      drive_disp(4'h7, 1'b1, 16'(t), 4'h0, 1'b1, 16'(t), 4'h0, 4'(t));
      cyc();
    end
    drive_disp(4'h8, 1'b1, 16'h00FF, 4'h0, 1'b1, 16'h00FF, 4'h0, 4'hF);
    flush = 1'b1;
    cyc();
    idle();
    check("t6_count", {29'b0, count}, 32'd0);
    check("t6_valid", {31'b0, issue_valid}, 32'd0);
    check("t6_full", {31'b0, full}, 32'd0);
    issue_ready = 1'b1;
    cyc(); cyc();
    check("t6_absent", {31'b0, issue_valid}, 32'd0);

    // Asynchronous reset mid-cycle with a pending issue.
    issue_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      drive_disp(4'h9, 1'b1, 16'(t), 4'h0, 1'b1, 16'(t), 4'h0, 4'(t));
      cyc();
    end
    idle();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_iv = 1'b0;
    check("rst_valid", {31'b0, issue_valid}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_a", {16'b0, issue_a}, 32'd0);
    check("rst_tag", {28'b0, issue_rob_tag}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    issue_ready = 1'b1;
    cyc(); cyc(); cyc();
    check("rst_no_stale", {31'b0, issue_valid}, 32'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      issue_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) begin
        drive_disp(4'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom_range(0, 7)), 4'($urandom));
      end
      for (int p = 0; p < CDB; p++) begin
        if ($urandom_range(0, 9) < 3) begin
          drive_cdb(p, 4'($urandom_range(0, 7)), 16'($urandom));
        end
      end
      flush = ($urandom_range(0, 99) == 0);
      cyc();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
